// File: rtl/i2c_byte_master.sv
// i2c_byte_master: one-byte I2C write/read engine timed by the stretch generator's data_clk phases.
// Optional: define I2C_MASTER_ACK_CHECK_EN to sample slave ACK slots and abort on address NACK.
module i2c_byte_master #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_clk_i,
  input  logic              sda_in_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic              cmd_rw_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              sda_oe_o,
  output logic              scl_not_ena_o,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_nack_o
);
  localparam int CW = $clog2(DATA_W + 1);
  typedef enum logic [3:0] {IDLE, START, ADDR, ACK1, WR, ACK2, RD, MACK, STOP} state_t;
  state_t state_q, state_d;
  logic dc_q, rise, fall;
  logic sda_q, sda_d, scl_q, scl_d, vld_q, vld_d, nack_q, nack_d, rw_q, rw_d;
  logic [ADDR_W:0] ash_q, ash_d;
  logic [DATA_W-1:0] wsh_q, wsh_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  assign rise = data_clk_i & ~dc_q;
  assign fall = ~data_clk_i & dc_q;
  // cnt_q doubles as the sub-phase index inside START and STOP
  always_comb begin
    state_d = state_q;
    sda_d = sda_q;
    scl_d = scl_q;
    vld_d = 1'b0;
    nack_d = nack_q;
    rw_d = rw_q;
    ash_d = ash_q;
    wsh_d = wsh_q;
    rd_d = rd_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (cmd_valid_i) begin
        state_d = START;
        ash_d = {cmd_addr_i, cmd_rw_i};
        wsh_d = cmd_wdata_i;
        rw_d = cmd_rw_i;
        rd_d = '0;
        nack_d = 1'b0;
        cnt_d = '0;
      end
      START: if (rise && cnt_q == '0) begin
        sda_d = 1'b1;
        cnt_d = CW'(1);
      end else if (fall && cnt_q != '0) begin
        scl_d = 1'b0;
        cnt_d = '0;
        state_d = ADDR;
      end
      ADDR: if (rise) begin
        sda_d = ~ash_q[ADDR_W];
        ash_d = ash_q << 1;
        cnt_d = cnt_q + CW'(1);
      end else if (fall && cnt_q == CW'(ADDR_W + 1)) begin
        cnt_d = '0;
        state_d = ACK1;
      end
      ACK1: if (rise) sda_d = 1'b0;
      else if (fall) begin
`ifdef I2C_MASTER_ACK_CHECK_EN
        nack_d = sda_in_i;
        state_d = sda_in_i ? STOP : rw_q ? RD : WR;
`else
        state_d = rw_q ? RD : WR;
`endif
        cnt_d = '0;
      end
      WR: if (rise) begin
        sda_d = ~wsh_q[DATA_W-1];
        wsh_d = wsh_q << 1;
        cnt_d = cnt_q + CW'(1);
      end else if (fall && cnt_q == CW'(DATA_W)) begin
        cnt_d = '0;
        state_d = ACK2;
      end
      ACK2: if (rise) sda_d = 1'b0;
      else if (fall) begin
`ifdef I2C_MASTER_ACK_CHECK_EN
        nack_d = nack_q | sda_in_i;
`endif
        cnt_d = '0;
        state_d = STOP;
      end
      RD: if (rise) sda_d = 1'b0;
      else if (fall) begin
        rd_d = {rd_q[DATA_W-2:0], sda_in_i};
        cnt_d = cnt_q == CW'(DATA_W - 1) ? '0 : cnt_q + CW'(1);
        state_d = cnt_q == CW'(DATA_W - 1) ? MACK : RD;
      end
      MACK: if (rise) sda_d = 1'b0;
      else if (fall) begin
        cnt_d = '0;
        state_d = STOP;
      end
      STOP: if (rise && cnt_q == '0) begin
        sda_d = 1'b1;
        cnt_d = CW'(1);
      end else if (fall && cnt_q == CW'(1)) begin
        scl_d = 1'b1;
        cnt_d = CW'(2);
      end else if (rise && cnt_q == CW'(2)) begin
        sda_d = 1'b0;
        vld_d = 1'b1;
        cnt_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dc_q <= 1'b0;
      sda_q <= 1'b0;
      scl_q <= 1'b1;
      vld_q <= 1'b0;
      nack_q <= 1'b0;
      rw_q <= 1'b0;
      ash_q <= '0;
      wsh_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      dc_q <= data_clk_i;
      sda_q <= sda_d;
      scl_q <= scl_d;
      vld_q <= vld_d;
      nack_q <= nack_d;
      rw_q <= rw_d;
      ash_q <= ash_d;
      wsh_q <= wsh_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  assign cmd_ready_o = state_q == IDLE;
  assign sda_oe_o = sda_q;
  assign scl_not_ena_o = scl_q;
  assign rsp_valid_o = vld_q;
  assign rsp_rdata_o = rd_q;
  assign rsp_nack_o = nack_q;
endmodule

// File: doc/i2c_byte_master.md
# i2c_byte_master

Single-byte I2C master transaction engine, sitting directly downstream of the I2C clock-stretch generator. It consumes that block's `data_clk` phase clock to time START, address, data, ACK and STOP bits on SDA. It returns `scl_not_ena` to the generator to gate SCL activity. A simple valid/ready command port on the host side launches one 1-byte write or 1-byte read per transaction.

## Interface
- `ADDR_W`, 7: I2C slave address width.
- `DATA_W`, 8: payload width; bit counter sized `$clog2(DATA_W+1)`.
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `data_clk`  in  1  phase clock from the stretch generator.
  - Rise = mid-SCL-low, the SDA change point.
  - Fall = mid-SCL-high, the SDA sample point.
- `sda_in`  in  1  synchronised SDA pin level.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_addr`  in  ADDR_W  slave address.
- `cmd_rw`  in  1  0 = write, 1 = read.
- `cmd_wdata`  in  DATA_W  write byte.
- `sda_oe`  out  1  1 = pull SDA low; 0 = release.
- `scl_not_ena`  out  1  to the generator; 1 = SCL idle/released, 0 = SCL toggling.
- `rsp_valid`  out  1  one-cycle pulse at transaction end.
- `rsp_rdata`  out  DATA_W  read byte, valid with `rsp_valid`.
- `rsp_nack`  out  1  slave NACK flag, valid with `rsp_valid`.

## Operation
- Edge detection:
  - `data_clk` is registered into `dc_q`.
  - `rise = data_clk & ~dc_q`; `fall = ~data_clk & dc_q`.
  - All state changes happen only on `rise` or `fall` cycles, except the command accept.
- Shift register: `{addr, rw}`, then data, MSB first.
- States and transitions:
  - IDLE:
    - `sda_oe=0`, `scl_not_ena=1`, `cmd_ready=1`.
    - On `cmd_valid & cmd_ready`: latch the command, clear `rsp_nack`, go to START.
  - START:
    - On the first `rise`: `sda_oe=1` (SDA falls while SCL high).
    - On the next `fall`: `scl_not_ena=0`, go to ADDR.
  - ADDR: on each `rise`, drive `sda_oe = ~bit`. After 8 bits, go to ACK1.
  - ACK1:
    - On `rise`: `sda_oe=0`.
    - On `fall`: sample `sda_in`; 1 sets `rsp_nack`.
    - Next state: WR if `rw=0`, RD if `rw=1`; see Configuration for the NACK case.
  - WR: 8 bits as in ADDR, then ACK2 (same as ACK1), then STOP.
  - RD:
    - `sda_oe=0`.
    - On each `fall`, shift `sda_in` into `rsp_rdata` LSB.
    - After 8 bits, go to MACK.
  - MACK: drive NACK (`sda_oe=0`) for one bit on `rise`. On `fall`, go to STOP.
  - STOP:
    - On `rise`: `sda_oe=1`.
    - On `fall`: `scl_not_ena=1`.
    - On the next `rise`: `sda_oe=0` (SDA rises while SCL high), pulse `rsp_valid`, go to IDLE.
- Simultaneous events:
  - `cmd_valid` while not IDLE is ignored; `cmd_ready=0`.
  - A `rise` in the same cycle as the command accept is not consumed by START; START waits for the next `rise`.

## Timing
- Reset values, one cycle after `rst` is sampled high:
  - `sda_oe=0`, `scl_not_ena=1`, `cmd_ready=1`.
  - `rsp_valid=0`, `rsp_rdata=0`, `rsp_nack=0`.
  - `dc_q=0`, state IDLE.
- `rst` mid-transaction: the bus is released immediately (next edge). No `rsp_valid` is issued.
- Output latency: outputs change in the cycle after the `data_clk` edge appears (one-cycle edge-detect latency). All outputs are registered.
- Clock stretching: while the generator holds `data_clk` static, no transitions occur. No timeout exists.
- Transaction length in `data_clk` periods:
  - Write: 1 (START) + 9 + 9 + 1 (STOP) + 1 = 21.
  - Read: 21, counting MACK in place of ACK2.
- `rsp_valid` is high for exactly one `clk` cycle. `cmd_ready` returns high in that same cycle.

## Configuration
- `I2C_MASTER_ACK_CHECK_EN`:
  - Defined: a NACK sampled in ACK1 skips WR/RD and goes straight to STOP, with `rsp_nack=1` and `rsp_rdata=0`. A NACK in ACK2 sets `rsp_nack`.
  - Undefined: ACK slots are still released for one bit, but `sda_in` is not sampled there. `rsp_nack` is tied 0 and the transaction always completes fully.

## Test plan
- Write, slave ACKs every slot: `cmd_addr=7'h50`, `rw=0`, `wdata=8'hA5`.
  - Required: SDA bit sequence `1010000_0`, ack, `10100101`, ack, then STOP.
  - Required: `rsp_valid` pulse with `rsp_nack=0`, 21 `data_clk` periods after the first `rise`.
- Read: `addr=7'h3C`, `rw=1`, slave drives `8'h96`.
  - Required: `rsp_rdata=8'h96`, master NACK slot released, STOP, `rsp_nack=0`.
- Address NACK (macro defined): `sda_in` held 1.
  - Required: STOP immediately after ACK1, `rsp_nack=1`, `rsp_rdata=0`.
  - With the macro undefined: full 21-period transaction, `rsp_nack=0`.
- Stretch: hold `data_clk` constant for 500 cycles mid-ADDR.
  - Required: `sda_oe` and state frozen; resumes with the correct next bit.
- Reset at bit 4 of WR.
  - Required: next cycle `sda_oe=0`, `scl_not_ena=1`, `cmd_ready=1`, no `rsp_valid`.
  - Required: a new command then completes normally.
- Back-to-back: `cmd_valid` held high across two commands.
  - Required: the second command is accepted only in the `rsp_valid` cycle or later; its `cmd_valid` is ignored during the first transaction.
